// File: rtl/clb_array.sv
// Array of N K-input LUT cells with a serial shadow configuration chain.
// Each cell output is either the LUT value or a clock-enabled flip-flop of it.
module clb_array #(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic           f_clk,
    input  logic           rst,
    input  logic           cfg_en,
    input  logic           cfg_in,
    input  logic           cfg_load,
    input  logic [N-1:0]   ce,
    input  logic [N*K-1:0] din,
    output logic           cfg_out,
    output logic           cfg_full,
    output logic           cfg_err,
    output logic [N-1:0]   y
);

    localparam int TW    = 1 << K;
    localparam int CELLW = TW + 2;
    localparam int CW    = N * CELLW;
    localparam int CNTW  = $clog2(CW + 1);

    logic [CW-1:0]   shadow_q, shadow_d;
    logic [CW-1:0]   active_q, active_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            err_q, err_d;
    logic [N-1:0]    q_q, q_d;

    logic [N-1:0]    lut;
    logic [N-1:0]    mode;
    logic            full;
    logic            load_ok;

    assign full    = (count_q == CNTW'(CW));
    assign load_ok = cfg_load & full;

    // LUT lookup runs purely from the active image, never from the shadow.
    for (genvar i = 0; i < N; i++) begin : g_cell
        logic [TW-1:0] truth;
        assign truth   = active_q[i*CELLW +: TW];
        assign lut[i]  = truth[din[i*K +: K]];
        assign mode[i] = active_q[i*CELLW + TW];
    end

    assign y        = (mode & q_q) | (~mode & lut);
    assign cfg_out  = shadow_q[CW-1];
    assign cfg_full = full;
    assign cfg_err  = err_q;

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        active_d = active_q;
        err_d    = err_q;
        q_d      = q_q;

        if (cfg_en) begin
            shadow_d = {shadow_q[CW-2:0], cfg_in};
        end

        // Commit uses the shadow as it stood before any same-cycle shift.
        if (load_ok) begin
            active_d = shadow_q;
            count_d  = cfg_en ? CNTW'(1) : '0;
        end else begin
            if (cfg_en && !full) begin
                count_d = count_q + CNTW'(1);
            end
            if (cfg_load) begin
                err_d = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (load_ok) begin
                q_d[i] = active_d[i*CELLW + TW + 1];
            end else if (ce[i]) begin
                q_d[i] = lut[i];
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
            q_q      <= q_d;
        end
    end

endmodule
